top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 Parameter WORD_SIZE, default 64, width of one name component word.
REQ-002 Parameter POINTER_SIZE, default 16, width of trie node pointers.
REQ-003 Parameter MAX_NAME_LENGTH, default 16, name length in words.
REQ-004 Parameter TREE_HEIGHT, default 4, number of trie levels and pipeline stages; legal range 1..MAX_NAME_LENGTH.
REQ-005 Parameter ENTRIES_PER_LEVEL, default 16, node slots per level; legal range 1..2^POINTER_SIZE-1.
REQ-006 Parameter FACE_WIDTH, default 8, width of the outgoing face id.
REQ-007 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-008 Port rst_n, input, 1, synchronous active-low reset.
REQ-009 Port next_name_in, input, unpacked array [MAX_NAME_LENGTH] of WORD_SIZE, name words; index 0 is the first component; zero-padded.
REQ-010 Port wr_en, input, 1, table write strobe.
REQ-011 Port wr_level, input, clog2(TREE_HEIGHT) (min 1), level to write.
REQ-012 Port wr_index, input, clog2(ENTRIES_PER_LEVEL) (min 1), slot to write.
REQ-013 Port wr_entry, input, packed {valid, has_face, face[FACE_WIDTH], parent[POINTER_SIZE], component[WORD_SIZE]}.
REQ-014 Port out_valid, output, 1, a lookup result is present.
REQ-015 Port out_hit, output, 1, at least one prefix carried a face.
REQ-016 Port out_face, output, FACE_WIDTH, face of the longest matching prefix.
REQ-017 Port out_match_len, output, clog2(TREE_HEIGHT+1), number of components in the longest face-bearing match.

Function
REQ-018 Name length = index of the first all-zero word in next_name_in, or MAX_NAME_LENGTH if none; all words after the first zero word are ignored.
REQ-019 A lookup is launched every rising edge; a zero-length name launches a bubble (no out_valid).
REQ-020 Node pointer of slot i at level k is i+1; pointer 0 denotes the root.
REQ-021 Stage k (0..TREE_HEIGHT-1) matches name word k against valid level-k entries whose parent equals the pointer from stage k-1 (root 0 for stage 0); lowest matching index wins.
REQ-022 Stage k is skipped (no match) if k >= name length or the incoming pointer is a miss; a miss at any stage is sticky for later stages.
REQ-023 On a match with has_face=1, the running best becomes {face, k+1}; otherwise the running best is unchanged.
REQ-024 Latency: result for the name sampled at edge N is presented after edge N+TREE_HEIGHT; throughput one lookup per cycle.
REQ-025 out_hit=1 iff the running best is set; if out_hit=0 then out_face=0 and out_match_len=0.
REQ-026 Components beyond TREE_HEIGHT are not searched.
REQ-027 A write on edge N takes effect for stage lookups evaluated after edge N; a lookup in the same stage on the same edge uses the old content.
REQ-028 Outputs are registered and hold their value when out_valid=0 until the next result.

Reset
REQ-029 While rst_n=0 at a rising edge: all table valid bits cleared, all pipeline valid bits cleared, out_valid=0, out_hit=0, out_face=0, out_match_len=0.
REQ-030 Reset mid-operation discards all in-flight lookups; writes with wr_en during reset are ignored.
REQ-031 First possible out_valid=1 is TREE_HEIGHT edges after the first edge with rst_n=1.

Structure
REQ-032 Package top_pkg holds the fib_entry_t packed struct, lookup-stage payload struct, and the default parameter constants.
REQ-033 One sub-module, fib_level_stage, instantiated TREE_HEIGHT times via generate; each owns its level table and pipeline register.

Verification
REQ-034 Reset, then name {"a",0,...} with an empty table -> after 4 cycles out_valid=1, out_hit=0, out_face=0, out_match_len=0.
REQ-035 Level0 slot0 {"a", face 3}, level1 slot2 {parent 1, "b", face 7}; name a/b/c -> out_hit=1, out_face=7, out_match_len=2.
REQ-036 Same table, name a/x -> out_face=3, out_match_len=1; name x/b -> out_hit=0.
REQ-037 All-zero name each cycle -> out_valid stays 0; back-to-back names a/b then a -> consecutive results 7 then 3 on adjacent cycles.
REQ-038 Assert rst_n=0 for one cycle with lookups in flight -> out_valid=0 for the next 4 cycles and table empty (name a/b -> out_hit=0).
REQ-039 Two level0 entries both "a" at slots 1 (face 5) and 0 (face 3) -> out_face=3.

Source files
------------

// File: rtl/top_pkg.sv
// Shared types and default sizing for the name-prefix FIB lookup pipeline.
package top_pkg;

  localparam int WORD_SIZE_D         = 64;
  localparam int POINTER_SIZE_D      = 16;
  localparam int MAX_NAME_LENGTH_D   = 16;
  localparam int TREE_HEIGHT_D       = 4;
  localparam int ENTRIES_PER_LEVEL_D = 16;
  localparam int FACE_WIDTH_D        = 8;

  // One trie node as written through wr_entry (valid is the MSB).
  typedef struct packed {
    logic                      valid;
    logic                      has_face;
    logic [FACE_WIDTH_D-1:0]   face;
    logic [POINTER_SIZE_D-1:0] parent;
    logic [WORD_SIZE_D-1:0]    component;
  } fib_entry_t;

  // Per-lookup state handed from one level stage to the next.
  typedef struct packed {
    logic                                   valid;
    logic [$clog2(MAX_NAME_LENGTH_D+1)-1:0] name_len;
    logic [POINTER_SIZE_D-1:0]              ptr;
    logic                                   miss;
    logic                                   best_hit;
    logic [FACE_WIDTH_D-1:0]                best_face;
    logic [$clog2(TREE_HEIGHT_D+1)-1:0]     best_len;
  } stage_payload_t;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/top_fib_level_stage.sv
// One trie level: owns its node table and the pipeline register holding the
// lookup state after this level has been searched.
module fib_level_stage
  import top_pkg::*;
#(
  parameter int WORD_SIZE         = WORD_SIZE_D,
  parameter int POINTER_SIZE      = POINTER_SIZE_D,
  parameter int TREE_HEIGHT       = TREE_HEIGHT_D,
  parameter int ENTRIES_PER_LEVEL = ENTRIES_PER_LEVEL_D,
  parameter int FACE_WIDTH        = FACE_WIDTH_D,
  parameter int LEVEL             = 0,
  parameter int NLEN_W            = 5,
  parameter int LEN_W             = 3,
  parameter int IDX_W             = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 i_wr_en,
  input  logic [IDX_W-1:0]                     i_wr_index,
  input  logic [2+FACE_WIDTH+POINTER_SIZE+WORD_SIZE-1:0] i_wr_entry,
  input  logic                                 i_valid,
  input  logic [NLEN_W-1:0]                    i_len,
  input  logic [TREE_HEIGHT-1:0][WORD_SIZE-1:0] i_words,
  input  logic [POINTER_SIZE-1:0]              i_ptr,
  input  logic                                 i_miss,
  input  logic                                 i_hit,
  input  logic [FACE_WIDTH-1:0]                i_face,
  input  logic [LEN_W-1:0]                     i_blen,
  output logic                                 o_valid,
  output logic [NLEN_W-1:0]                    o_len,
  output logic [TREE_HEIGHT-1:0][WORD_SIZE-1:0] o_words,
  output logic [POINTER_SIZE-1:0]              o_ptr,
  output logic                                 o_miss,
  output logic                                 o_hit,
  output logic [FACE_WIDTH-1:0]                o_face,
  output logic [LEN_W-1:0]                     o_blen
);

  typedef struct packed {
    logic                    valid;
    logic                    has_face;
    logic [FACE_WIDTH-1:0]   face;
    logic [POINTER_SIZE-1:0] parent;
    logic [WORD_SIZE-1:0]    component;
  } entry_t;

  entry_t                        w_wr;
  logic [ENTRIES_PER_LEVEL-1:0]  r_vld;
  logic                          r_hf     [ENTRIES_PER_LEVEL];
  logic [FACE_WIDTH-1:0]         r_face_t [ENTRIES_PER_LEVEL];
  logic [POINTER_SIZE-1:0]       r_parent [ENTRIES_PER_LEVEL];
  logic [WORD_SIZE-1:0]          r_comp   [ENTRIES_PER_LEVEL];

  logic                    w_found;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_active;
  logic [POINTER_SIZE-1:0] w_n_ptr;
  logic                    w_n_miss;
  logic                    w_n_hit;
  logic [FACE_WIDTH-1:0]   w_n_face;
  logic [LEN_W-1:0]        w_n_blen;

  logic                                  r_valid;
  logic [NLEN_W-1:0]                     r_len;
  logic [TREE_HEIGHT-1:0][WORD_SIZE-1:0] r_words;
  logic [POINTER_SIZE-1:0]               r_ptr;
  logic                                  r_miss;
  logic                                  r_hit;
  logic [FACE_WIDTH-1:0]                 r_face;
  logic [LEN_W-1:0]                      r_blen;

  assign w_wr = i_wr_entry;

  // Table write port; reset only invalidates, node contents are don't-care.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else if (i_wr_en) begin
      r_vld[i_wr_index]    <= w_wr.valid;
      r_hf[i_wr_index]     <= w_wr.has_face;
      r_face_t[i_wr_index] <= w_wr.face;
      r_parent[i_wr_index] <= w_wr.parent;
      r_comp[i_wr_index]   <= w_wr.component;
    end
  end

  // Child search under the incoming pointer; scanning downward leaves the lowest slot.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = ENTRIES_PER_LEVEL - 1; i >= 0; i--) begin
      if (r_vld[i] && (r_parent[i] == i_ptr) && (r_comp[i] == i_words[LEVEL])) begin
        w_found = 1'b1;
        w_idx   = IDX_W'(i);
      end
    end
  end

  assign w_active = i_valid && !i_miss && (NLEN_W'(LEVEL) < i_len);

  // Advance the walk: follow the match, remember the deepest face, or go sticky-miss.
  always_comb begin
    w_n_ptr  = i_ptr;
    w_n_miss = i_miss;
    w_n_hit  = i_hit;
    w_n_face = i_face;
    w_n_blen = i_blen;
    if (w_active) begin
      if (w_found) begin
        w_n_ptr = POINTER_SIZE'(w_idx) + POINTER_SIZE'(1);
        if (r_hf[w_idx]) begin
          w_n_hit  = 1'b1;
          w_n_face = r_face_t[w_idx];
          w_n_blen = LEN_W'(LEVEL + 1);
        end
      end else begin
        w_n_miss = 1'b1;
      end
    end
  end

  // Pipeline register; only the valid bit needs clearing to drop in-flight lookups.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
    end
    r_len   <= i_len;
    r_words <= i_words;
    r_ptr   <= w_n_ptr;
    r_miss  <= w_n_miss;
    r_hit   <= w_n_hit;
    r_face  <= w_n_face;
    r_blen  <= w_n_blen;
  end

  assign o_valid = r_valid;
  assign o_len   = r_len;
  assign o_words = r_words;
  assign o_ptr   = r_ptr;
  assign o_miss  = r_miss;
  assign o_hit   = r_hit;
  assign o_face  = r_face;
  assign o_blen  = r_blen;

endmodule

// File: rtl/top.sv
// Longest-prefix name lookup: a pipelined trie walk, one level per stage,
// one lookup launched per clock, registered result TREE_HEIGHT edges later.
module top
  import top_pkg::*;
#(
  parameter int WORD_SIZE         = WORD_SIZE_D,
  parameter int POINTER_SIZE      = POINTER_SIZE_D,
  parameter int MAX_NAME_LENGTH   = MAX_NAME_LENGTH_D,
  parameter int TREE_HEIGHT       = TREE_HEIGHT_D,
  parameter int ENTRIES_PER_LEVEL = ENTRIES_PER_LEVEL_D,
  parameter int FACE_WIDTH        = FACE_WIDTH_D
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [WORD_SIZE-1:0]                        next_name_in [MAX_NAME_LENGTH],
  input  logic                                        wr_en,
  input  logic [clog2_min1(TREE_HEIGHT)-1:0]          wr_level,
  input  logic [clog2_min1(ENTRIES_PER_LEVEL)-1:0]    wr_index,
  input  logic [2+FACE_WIDTH+POINTER_SIZE+WORD_SIZE-1:0] wr_entry,
  output logic                                        out_valid,
  output logic                                        out_hit,
  output logic [FACE_WIDTH-1:0]                       out_face,
  output logic [$clog2(TREE_HEIGHT+1)-1:0]            out_match_len
);

  localparam int LVL_W  = clog2_min1(TREE_HEIGHT);
  localparam int IDX_W  = clog2_min1(ENTRIES_PER_LEVEL);
  localparam int LEN_W  = $clog2(TREE_HEIGHT + 1);
  localparam int NLEN_W = $clog2(MAX_NAME_LENGTH + 1);

  logic                                  w_valid [TREE_HEIGHT+1];
  logic [NLEN_W-1:0]                     w_len   [TREE_HEIGHT+1];
  logic [TREE_HEIGHT-1:0][WORD_SIZE-1:0] w_words [TREE_HEIGHT+1];
  logic [POINTER_SIZE-1:0]               w_ptr   [TREE_HEIGHT+1];
  logic                                  w_miss  [TREE_HEIGHT+1];
  logic                                  w_hit   [TREE_HEIGHT+1];
  logic [FACE_WIDTH-1:0]                 w_face  [TREE_HEIGHT+1];
  logic [LEN_W-1:0]                      w_blen  [TREE_HEIGHT+1];

  logic              w_zero_seen;
  logic [NLEN_W-1:0] w_name_len;
  logic              w_tail_unused;

  // Name length is the position of the first all-zero word; later words are ignored.
  always_comb begin
    w_zero_seen = 1'b0;
    w_name_len  = NLEN_W'(MAX_NAME_LENGTH);
    for (int i = 0; i < MAX_NAME_LENGTH; i++) begin
      if (!w_zero_seen && (next_name_in[i] == '0)) begin
        w_zero_seen = 1'b1;
        w_name_len  = NLEN_W'(i);
      end
    end
  end

  // Launch state: walk starts at the root with no best match yet.
  assign w_valid[0] = (w_name_len != '0);
  assign w_len[0]   = w_name_len;
  assign w_ptr[0]   = '0;
  assign w_miss[0]  = 1'b0;
  assign w_hit[0]   = 1'b0;
  assign w_face[0]  = '0;
  assign w_blen[0]  = '0;

  for (genvar k = 0; k < TREE_HEIGHT; k++) begin : g_word
    assign w_words[0][k] = next_name_in[k];
  end

  for (genvar k = 0; k < TREE_HEIGHT; k++) begin : g_stage
    logic w_wr_sel;
    assign w_wr_sel = wr_en && (wr_level == LVL_W'(k));

    fib_level_stage #(
      .WORD_SIZE        (WORD_SIZE),
      .POINTER_SIZE     (POINTER_SIZE),
      .TREE_HEIGHT      (TREE_HEIGHT),
      .ENTRIES_PER_LEVEL(ENTRIES_PER_LEVEL),
      .FACE_WIDTH       (FACE_WIDTH),
      .LEVEL            (k),
      .NLEN_W           (NLEN_W),
      .LEN_W            (LEN_W),
      .IDX_W            (IDX_W)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_wr_sel),
      .i_wr_index(wr_index),
      .i_wr_entry(wr_entry),
      .i_valid   (w_valid[k]),
      .i_len     (w_len[k]),
      .i_words   (w_words[k]),
      .i_ptr     (w_ptr[k]),
      .i_miss    (w_miss[k]),
      .i_hit     (w_hit[k]),
      .i_face    (w_face[k]),
      .i_blen    (w_blen[k]),
      .o_valid   (w_valid[k+1]),
      .o_len     (w_len[k+1]),
      .o_words   (w_words[k+1]),
      .o_ptr     (w_ptr[k+1]),
      .o_miss    (w_miss[k+1]),
      .o_hit     (w_hit[k+1]),
      .o_face    (w_face[k+1]),
      .o_blen    (w_blen[k+1])
    );
  end

  // Walk bookkeeping past the last level has no consumer.
  assign w_tail_unused = ^{w_len[TREE_HEIGHT], w_words[TREE_HEIGHT],
                           w_ptr[TREE_HEIGHT], w_miss[TREE_HEIGHT]};

  // Result register; hit/face/length hold between valid results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_hit       <= 1'b0;
      out_face      <= '0;
      out_match_len <= '0;
    end else begin
      out_valid <= w_valid[TREE_HEIGHT];
      if (w_valid[TREE_HEIGHT]) begin
        out_hit       <= w_hit[TREE_HEIGHT];
        out_face      <= w_face[TREE_HEIGHT];
        out_match_len <= w_blen[TREE_HEIGHT];
      end
    end
  end

endmodule

// File: tb/tb_top.sv
// Bench for the FIB lookup pipeline: a queue of expected results computed by
// a direct prefix walk over a shadow table, compared every cycle.
module tb_top;
  import top_pkg::*;

  localparam int W = 64;
  localparam int H = 4;
  localparam int M = 16;
  localparam int E = 16;
  localparam int F = 8;
  localparam int LAT = H + 1;

  localparam logic [W-1:0] A = 64'h61;
  localparam logic [W-1:0] B = 64'h62;
  localparam logic [W-1:0] C = 64'h63;
  localparam logic [W-1:0] X = 64'h78;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         rst_n = 1'b0;
  logic [W-1:0]                 next_name_in [M];
  logic                         wr_en = 1'b0;
  logic [1:0]                   wr_level = '0;
  logic [3:0]                   wr_index = '0;
  logic [$bits(fib_entry_t)-1:0] wr_entry = '0;
  logic                         out_valid;
  logic                         out_hit;
  logic [F-1:0]                 out_face;
  logic [2:0]                   out_match_len;

  top #(
    .WORD_SIZE(W), .POINTER_SIZE(16), .MAX_NAME_LENGTH(M),
    .TREE_HEIGHT(H), .ENTRIES_PER_LEVEL(E), .FACE_WIDTH(F)
  ) dut (
    .clk(clk), .rst_n(rst_n), .next_name_in(next_name_in),
    .wr_en(wr_en), .wr_level(wr_level), .wr_index(wr_index), .wr_entry(wr_entry),
    .out_valid(out_valid), .out_hit(out_hit), .out_face(out_face),
    .out_match_len(out_match_len)
  );

  typedef logic [W-1:0] name_t [M];
  typedef struct {
    bit           rst;
    bit           v;
    bit           hit;
    logic [F-1:0] face;
    int           len;
  } item_t;

  item_t      q[$];
  fib_entry_t mt [H][E];
  bit         mv [H][E];
  int         checks = 0;
  int         failures = 0;
  bit         m_hit = 0;
  logic [F-1:0] m_face = '0;
  int         m_len = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Longest face-bearing prefix of nm, found by walking the shadow trie.
  function automatic item_t model(input name_t nm);
    item_t it;
    int    len;
    int    parent_ptr;
    int    slot;
    it = '{default: 0};
    len = M;
    for (int i = 0; i < M; i++) if (nm[i] == '0 && len == M) len = i;
    it.v = (len != 0);
    parent_ptr = 0;
    for (int lvl = 0; lvl < H && lvl < len; lvl++) begin
      slot = -1;
      for (int s = 0; s < E; s++)
        if (slot < 0 && mv[lvl][s] && int'(mt[lvl][s].parent) == parent_ptr &&
            mt[lvl][s].component == nm[lvl])
          slot = s;
      if (slot < 0) break;
      parent_ptr = slot + 1;
      if (mt[lvl][slot].has_face) begin
        it.hit  = 1;
        it.face = mt[lvl][slot].face;
        it.len  = lvl + 1;
      end
    end
    return it;
  endfunction

  function automatic name_t nm3(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] c);
    name_t n;
    foreach (n[i]) n[i] = '0;
    n[0] = a; n[1] = b; n[2] = c;
    return n;
  endfunction

  function automatic fib_entry_t ent(input bit hf, input int face, input int parent,
                                     input logic [W-1:0] comp);
    fib_entry_t e;
    e.valid = 1'b1; e.has_face = hf; e.face = F'(face);
    e.parent = 16'(parent); e.component = comp;
    return e;
  endfunction

  // One clock: check the result due now, then drive this cycle's inputs.
  task automatic cycle(input name_t nm, input bit rst, input bit we, input int lvl,
                       input int idx, input fib_entry_t e);
    item_t it;
    @(negedge clk);
    if (q.size() == LAT) begin
      it = q.pop_front();
      if (it.rst) begin
        m_hit = 0; m_face = '0; m_len = 0;
      end else if (it.v) begin
        m_hit = it.hit; m_face = it.face; m_len = it.len;
      end
      check("out_valid", 64'(out_valid), 64'(it.v));
      check("out_hit", 64'(out_hit), 64'(m_hit));
      check("out_face", 64'(out_face), 64'(m_face));
      check("out_match_len", 64'(out_match_len), 64'(m_len));
    end
    rst_n        = !rst;
    next_name_in = nm;
    wr_en        = we;
    wr_level     = 2'(lvl);
    wr_index     = 4'(idx);
    wr_entry     = e;
    if (rst) begin
      q.delete();
      it = '{default: 0};
      it.rst = 1;
      q.push_back(it);
      it.rst = 0;
      repeat (LAT - 1) q.push_back(it);
      mv = '{default: 0};
    end else begin
      q.push_back(model(nm));
      if (we) begin
        mt[lvl][idx] = e;
        mv[lvl][idx] = e.valid;
      end
    end
  endtask

  task automatic look(input name_t nm);
    cycle(nm, 0, 0, 0, 0, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(nm3('0, '0, '0), 0, 0, 0, 0, '0);
  endtask

  task automatic rst_cycle();
    cycle(nm3('0, '0, '0), 1, 0, 0, 0, '0);
  endtask

  task automatic wr(input int lvl, input int idx, input fib_entry_t e);
    cycle(nm3('0, '0, '0), 0, 1, lvl, idx, e);
  endtask

  function automatic name_t rand_name();
    name_t n;
    int    len;
    foreach (n[i]) n[i] = '0;
    len = ($urandom_range(0, 9) == 0) ? M : int'($urandom_range(0, 6));
    for (int i = 0; i < len; i++) n[i] = 64'h60 + 64'($urandom_range(1, 3));
    for (int i = len + 1; i < M; i++)
      if ($urandom_range(0, 1) == 1) n[i] = 64'h60 + 64'($urandom_range(1, 3));
    return n;
  endfunction

  task automatic rand_table(input int n);
    fib_entry_t e;
    int lvl;
    for (int j = 0; j < n; j++) begin
      lvl = int'($urandom_range(0, H - 1));
      e = ent($urandom_range(0, 1) == 1, int'($urandom_range(1, 255)),
              (lvl == 0) ? (($urandom_range(0, 5) == 0) ? 1 : 0) : int'($urandom_range(0, 5)),
              64'h60 + 64'($urandom_range(1, 3)));
      e.valid = ($urandom_range(0, 7) != 0);
      wr(lvl, int'($urandom_range(0, 7)), e);
    end
  endtask

  initial begin
    foreach (next_name_in[i]) next_name_in[i] = '0;
    rst_cycle();
    cycle(nm3('0, '0, '0), 1, 1, 0, 0, ent(1, 9, 0, A));
    rst_cycle();

    look(nm3(A, '0, '0));
    idle(LAT);

    wr(0, 0, ent(1, 3, 0, A));
    wr(1, 2, ent(1, 7, 1, B));
    look(nm3(A, B, C));
    look(nm3(A, X, '0));
    look(nm3(X, B, '0));
    idle(3);
    look(nm3(A, B, '0));
    look(nm3(A, '0, '0));

    look(nm3(A, B, '0));
    look(nm3(A, '0, '0));
    rst_cycle();
    look(nm3(A, B, '0));
    idle(LAT);

    wr(0, 1, ent(1, 5, 0, A));
    wr(0, 0, ent(1, 3, 0, A));
    look(nm3(A, '0, '0));
    cycle(nm3(A, '0, '0), 0, 1, 0, 0, ent(1, 9, 0, A));
    look(nm3(A, '0, '0));
    idle(LAT);

    for (int round = 0; round < 3; round++) begin
      if (round == 0) rst_cycle();
      rand_table(40);
      for (int j = 0; j < 200; j++) look(rand_name());
      idle(H);
    end
    idle(LAT + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
